// File: rtl/nano6502_pkg.sv
// Shared nano6502 definitions for the DMA engine: IO bank, register map,
// CTRL/STATUS bit positions and the DMA FSM state type.
package nano6502_pkg;

    localparam logic [7:0] DMA_BANK   = 8'h08;

    localparam logic [2:0] REG_SRC_L  = 3'd0;
    localparam logic [2:0] REG_SRC_H  = 3'd1;
    localparam logic [2:0] REG_DST_L  = 3'd2;
    localparam logic [2:0] REG_DST_H  = 3'd3;
    localparam logic [2:0] REG_LEN_L  = 3'd4;
    localparam logic [2:0] REG_LEN_H  = 3'd5;
    localparam logic [2:0] REG_CTRL   = 3'd6;
    localparam logic [2:0] REG_STATUS = 3'd7;

    localparam int CTRL_START = 0;
    localparam int CTRL_FILL  = 1;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;

    // Wide enough for any practical grace / RAM latency wait
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STALL,
        ST_READ,
        ST_RWAIT,
        ST_WRITE,
        ST_RELEASE
    } dma_state_t;

endpackage

// File: rtl/dma_controller_if.sv
// RAM-port side of the DMA engine: grant plus the address/data/rwn it drives
// while it owns the shared instram port.
interface dma_controller_if #(parameter int ADDR_W = 16);
    logic              bus_grant_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              mem_rwn_o;
    logic [7:0]        mem_rdata_i;

    modport master (output bus_grant_o, mem_addr_o, mem_wdata_o, mem_rwn_o,
                    input  mem_rdata_i);
    modport slave  (input  bus_grant_o, mem_addr_o, mem_wdata_o, mem_rwn_o,
                    output mem_rdata_i);
endinterface

// File: rtl/dma_controller_stall_counter.sv
// Down-counter with load and zero flag; times both the CPU grace period
// and the RAM read latency (and the release tail).
module dma_stall_counter
    import nano6502_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/dma_controller.sv
// Memory-to-memory DMA engine: stalls the CPU via RDY, takes the RAM port and
// copies LEN bytes SRC->DST. Optional fill mode under `define DMA_FILL_EN.
module dma_controller
    import nano6502_pkg::*;
#(
    parameter int GRACE_CYCLES = 2,
    parameter int RAM_LAT      = 1,
    parameter int ADDR_W       = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    R_W_n,
    input  logic [2:0]              reg_addr_i,
    input  logic [2:0]              reg_addr_r_i,
    input  logic [7:0]              data_i,
    input  logic                    dma_cs,
    output logic [7:0]              data_o,
    output logic                    cpu_rdy_o,
    output logic                    done_o,
    dma_controller_if.master        mem
);
    logic [7:0]        src_l, src_h, dst_l, dst_h, len_l, len_h;
    logic              done_q;
    logic [ADDR_W-1:0] wsrc, wdst;
    logic [15:0]       wlen;
    dma_state_t        state;

    logic              reg_wr, busy, start, fill_mode;
    logic              cnt_load, cnt_zero;
    logic [CNT_W-1:0]  cnt_val;

    assign reg_wr = dma_cs & ~R_W_n;
    assign busy   = (state != ST_IDLE);
    assign start  = reg_wr && (reg_addr_i == REG_CTRL) && data_i[CTRL_START];
    assign done_o = done_q;

`ifdef DMA_FILL_EN
    logic fill_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            fill_q <= 1'b0;
        else if (reg_wr && !busy && reg_addr_i == REG_CTRL)
            fill_q <= data_i[CTRL_FILL];
    end
    assign fill_mode = fill_q;
`else
    assign fill_mode = 1'b0;
`endif

    // Counter reloads happen on the edge that enters the timed state
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            ST_IDLE:  if (start && {len_h, len_l} != 16'd0) begin
                          cnt_load = 1'b1;
                          cnt_val  = CNT_W'(GRACE_CYCLES - 1);
                      end
            ST_READ:  begin
                          cnt_load = 1'b1;
                          cnt_val  = CNT_W'(RAM_LAT - 1);
                      end
            ST_WRITE: if (wlen == 16'd1) begin
                          cnt_load = 1'b1;
                          cnt_val  = CNT_W'(1);
                      end
            default:  ;
        endcase
    end

    dma_stall_counter u_cnt (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            {src_l, src_h, dst_l, dst_h, len_l, len_h} <= '0;
            done_q          <= 1'b0;
            wsrc            <= '0;
            wdst            <= '0;
            wlen            <= '0;
            state           <= ST_IDLE;
            cpu_rdy_o       <= 1'b1;
            mem.bus_grant_o <= 1'b0;
            mem.mem_addr_o  <= '0;
            mem.mem_wdata_o <= '0;
            mem.mem_rwn_o   <= 1'b1;
        end else begin
            if (reg_wr && !busy) begin
                case (reg_addr_i)
                    REG_SRC_L: src_l <= data_i;
                    REG_SRC_H: src_h <= data_i;
                    REG_DST_L: dst_l <= data_i;
                    REG_DST_H: dst_h <= data_i;
                    REG_LEN_L: len_l <= data_i;
                    REG_LEN_H: len_h <= data_i;
                    default: ;
                endcase
            end
            if (reg_wr && reg_addr_i == REG_STATUS)
                done_q <= 1'b0;

            case (state)
                ST_IDLE: if (start) begin
                    if ({len_h, len_l} == 16'd0) begin
                        done_q <= 1'b1;
                    end else begin
                        done_q    <= 1'b0;
                        wsrc      <= ADDR_W'({src_h, src_l});
                        wdst      <= ADDR_W'({dst_h, dst_l});
                        wlen      <= {len_h, len_l};
                        cpu_rdy_o <= 1'b0;
                        state     <= ST_STALL;
                    end
                end
                ST_STALL: if (cnt_zero) begin
                    mem.bus_grant_o <= 1'b1;
                    if (fill_mode) begin
                        mem.mem_addr_o  <= wdst;
                        mem.mem_wdata_o <= src_l;
                        mem.mem_rwn_o   <= 1'b0;
                        state           <= ST_WRITE;
                    end else begin
                        mem.mem_addr_o  <= wsrc;
                        state           <= ST_READ;
                    end
                end
                ST_READ: state <= ST_RWAIT;
                ST_RWAIT: if (cnt_zero) begin
                    mem.mem_addr_o  <= wdst;
                    mem.mem_wdata_o <= mem.mem_rdata_i;
                    mem.mem_rwn_o   <= 1'b0;
                    state           <= ST_WRITE;
                end
                ST_WRITE: begin
                    wdst <= wdst + ADDR_W'(1);
                    wlen <= wlen - 16'd1;
                    if (!fill_mode)
                        wsrc <= wsrc + ADDR_W'(1);
                    if (wlen == 16'd1) begin
                        mem.mem_rwn_o   <= 1'b1;
                        mem.bus_grant_o <= 1'b0;
                        state           <= ST_RELEASE;
                    end else if (fill_mode) begin
                        // back-to-back writes, rwn stays low
                        mem.mem_addr_o  <= wdst + ADDR_W'(1);
                    end else begin
                        mem.mem_addr_o  <= wsrc + ADDR_W'(1);
                        mem.mem_rwn_o   <= 1'b1;
                        state           <= ST_READ;
                    end
                end
                ST_RELEASE: if (cnt_zero) begin
                    cpu_rdy_o <= 1'b1;
                    done_q    <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        data_o = '0;
        case (reg_addr_r_i)
            REG_SRC_L:  data_o = src_l;
            REG_SRC_H:  data_o = src_h;
            REG_DST_L:  data_o = dst_l;
            REG_DST_H:  data_o = dst_h;
            REG_LEN_L:  data_o = len_l;
            REG_LEN_H:  data_o = len_h;
            REG_CTRL:   data_o[CTRL_FILL] = fill_mode;
            default: begin
                data_o[STAT_BUSY] = busy;
                data_o[STAT_DONE] = done_q;
            end
        endcase
    end
endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: register table, copy, LEN=0, address
// wrap, mid-transfer reset, ignored writes while busy, optional fill.
module tb_dma_controller;
    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       R_W_n, dma_cs;
    logic [2:0] reg_addr_i, reg_addr_r_i;
    logic [7:0] data_i, data_o;
    logic       cpu_rdy_o, done_o;
    logic [7:0] rdata_q;
    logic [7:0] ram [0:65535];
    logic [7:0] v;
    int checks = 0, errors = 0;
    int stall_cnt = 0, grant_cnt = 0, wr_cnt = 0;

    dma_controller_if #(.ADDR_W(16)) mif ();

    dma_controller dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .R_W_n(R_W_n),
        .reg_addr_i(reg_addr_i), .reg_addr_r_i(reg_addr_r_i),
        .data_i(data_i), .dma_cs(dma_cs), .data_o(data_o),
        .cpu_rdy_o(cpu_rdy_o), .done_o(done_o), .mem(mif)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous RAM, one cycle read latency
    assign mif.mem_rdata_i = rdata_q;
    always @(posedge clk_i) begin
        if (mif.bus_grant_o && !mif.mem_rwn_o) begin
            ram[mif.mem_addr_o] <= mif.mem_wdata_o;
            wr_cnt = wr_cnt + 1;
        end
        rdata_q <= ram[mif.mem_addr_o];
    end

    always @(negedge clk_i) begin
        if (!cpu_rdy_o)       stall_cnt = stall_cnt + 1;
        if (mif.bus_grant_o)  grant_cnt = grant_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk_i);
        dma_cs = 1'b1; R_W_n = 1'b0; reg_addr_i = a; data_i = d;
        @(negedge clk_i);
        dma_cs = 1'b0; R_W_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        reg_addr_r_i = a;
        #1 d = data_o;
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] dd, input logic [15:0] l);
        wr(3'd0, s[7:0]);  wr(3'd1, s[15:8]);
        wr(3'd2, dd[7:0]); wr(3'd3, dd[15:8]);
        wr(3'd4, l[7:0]);  wr(3'd5, l[15:8]);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400; i++) begin
            if (done_o) break;
            @(negedge clk_i);
        end
        chk(name, int'(done_o), 1);
    endtask

    typedef struct {
        logic [2:0] addr;
        logic       do_wr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[8];

`ifdef DMA_FILL_EN
    localparam logic [7:0] CTRL_RB = 8'h02;
`else
    localparam logic [7:0] CTRL_RB = 8'h00;
`endif

    initial begin
        vecs[0] = '{3'd0, 1'b1, 8'h34, 8'h34};
        vecs[1] = '{3'd1, 1'b1, 8'h12, 8'h12};
        vecs[2] = '{3'd2, 1'b1, 8'h78, 8'h78};
        vecs[3] = '{3'd3, 1'b1, 8'h56, 8'h56};
        vecs[4] = '{3'd4, 1'b1, 8'h9A, 8'h9A};
        vecs[5] = '{3'd5, 1'b1, 8'hBC, 8'hBC};
        vecs[6] = '{3'd6, 1'b1, 8'h02, CTRL_RB};
        vecs[7] = '{3'd7, 1'b0, 8'h00, 8'h00};

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h11; ram[16'h1001] = 8'h22;
        ram[16'h1002] = 8'h33; ram[16'h1003] = 8'h44;
        ram[16'hFFFE] = 8'hA1; ram[16'hFFFF] = 8'hB2; ram[16'h0000] = 8'hC3;

        rst_n_i = 1'b0; dma_cs = 1'b0; R_W_n = 1'b1;
        reg_addr_i = '0; reg_addr_r_i = '0; data_i = '0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), v);
            chk("reset_reg", int'(v), 0);
        end
        chk("reset_rdy",   int'(cpu_rdy_o), 1);
        chk("reset_grant", int'(mif.bus_grant_o), 0);
        chk("reset_rwn",   int'(mif.mem_rwn_o), 1);
        chk("reset_addr",  int'(mif.mem_addr_o), 0);
        chk("reset_wdata", int'(mif.mem_wdata_o), 0);
        chk("reset_done",  int'(done_o), 0);

        // Register write / readback table
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, v);
            chk($sformatf("reg_tbl%0d", i), int'(v), int'(vecs[i].exp));
        end

        // Basic 4-byte copy
        setup(16'h1000, 16'h2000, 16'd4);
        stall_cnt = 0; wr_cnt = 0;
        wr(3'd6, 8'h01);
        rd(3'd7, v);
        chk("busy_status", int'(v), 8'h01);
        wait_done("copy_done");
        @(negedge clk_i);
        chk("copy_stall", stall_cnt, 16);
        chk("copy_wrcnt", wr_cnt, 4);
        chk("copy_b0", int'(ram[16'h2000]), 8'h11);
        chk("copy_b1", int'(ram[16'h2001]), 8'h22);
        chk("copy_b2", int'(ram[16'h2002]), 8'h33);
        chk("copy_b3", int'(ram[16'h2003]), 8'h44);
        rd(3'd7, v);
        chk("copy_status", int'(v), 8'h02);
        chk("copy_rdy", int'(cpu_rdy_o), 1);

        // LEN = 0: done next cycle, no stall, no grant
        wr(3'd7, 8'h00);
        chk("clr_done", int'(done_o), 0);
        wr(3'd4, 8'h00); wr(3'd5, 8'h00);
        stall_cnt = 0; grant_cnt = 0;
        wr(3'd6, 8'h01);
        chk("len0_done", int'(done_o), 1);
        repeat (4) @(negedge clk_i);
        chk("len0_stall", stall_cnt, 0);
        chk("len0_grant", grant_cnt, 0);

        // Address wrap 0xFFFE -> 0x0000
        setup(16'hFFFE, 16'h0100, 16'd3);
        stall_cnt = 0;
        wr(3'd6, 8'h01);
        wait_done("wrap_done");
        @(negedge clk_i);
        chk("wrap_stall", stall_cnt, 13);
        chk("wrap_b0", int'(ram[16'h0100]), 8'hA1);
        chk("wrap_b1", int'(ram[16'h0101]), 8'hB2);
        chk("wrap_b2", int'(ram[16'h0102]), 8'hC3);

        // Reset during the 3rd WRITE cycle
        setup(16'h1000, 16'h4000, 16'd4);
        wr_cnt = 0;
        wr(3'd6, 8'h01);
        begin
            int seen = 0;
            for (int i = 0; i < 200 && seen < 3; i++) begin
                if (mif.bus_grant_o && !mif.mem_rwn_o) seen++;
                if (seen < 3) @(negedge clk_i);
            end
            chk("rst_found_w3", seen, 3);
        end
        rst_n_i = 1'b0;
        #1;
        chk("rst_rdy",   int'(cpu_rdy_o), 1);
        chk("rst_grant", int'(mif.bus_grant_o), 0);
        chk("rst_rwn",   int'(mif.mem_rwn_o), 1);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        rd(3'd7, v);
        chk("rst_status", int'(v), 0);
        chk("rst_wrcnt", wr_cnt, 2);
        chk("rst_b0", int'(ram[16'h4000]), 8'h11);
        chk("rst_b1", int'(ram[16'h4001]), 8'h22);
        chk("rst_b2", int'(ram[16'h4002]), 8'h00);

        // Writes and re-start during a transfer are ignored
        setup(16'h1000, 16'h5000, 16'd4);
        stall_cnt = 0;
        wr(3'd6, 8'h01);
        wr(3'd0, 8'h55);
        wr(3'd6, 8'h01);
        wait_done("busy_done");
        @(negedge clk_i);
        chk("busy_stall", stall_cnt, 16);
        chk("busy_b0", int'(ram[16'h5000]), 8'h11);
        chk("busy_b3", int'(ram[16'h5003]), 8'h44);
        rd(3'd0, v);
        chk("busy_srcl", int'(v), 8'h00);
        wr(3'd7, 8'h00);
        rd(3'd7, v);
        chk("busy_status", int'(v), 8'h00);

`ifdef DMA_FILL_EN
        // Fill mode: one cycle per byte, SRC_L is the pattern
        setup(16'h00A5, 16'h3000, 16'd5);
        stall_cnt = 0;
        wr(3'd6, 8'h03);
        wait_done("fill_done");
        @(negedge clk_i);
        chk("fill_stall", stall_cnt, 9);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fill_b%0d", i), int'(ram[16'h3000 + i]), 8'hA5);
        chk("fill_after", int'(ram[16'h3005]), 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_controller.md
Name: dma_controller

Overview:
- Memory-to-memory DMA engine on IO bank 0x0008, registers at 0xFE00-0xFE07.
- Arbitrates the shared 64K instram port between cpu_65c02 and itself: stalls the CPU through RDY, takes the RAM port, copies LEN bytes SRC→DST, then returns the bus.
- Top level muxes RAM address, write address, data and rwn with bus_grant_o.

Parameters:
- GRACE_CYCLES, 2: cycles RDY is held low before the bus is taken, so the in-flight CPU access completes.
- RAM_LAT, 1: RAM read latency in clk_i cycles.
- ADDR_W, 16: memory address width.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- R_W_n  in  1  registered CPU read/write-n, aligned with reg_addr_i
- reg_addr_i  in  3  registered register write address (cpu_addr_w[2:0])
- reg_addr_r_i  in  3  unregistered register read address (cpu_addr[2:0])
- data_i  in  8  CPU write data
- dma_cs  in  1  bank select from addr_decoder
- data_o  out  8  register read data
- cpu_rdy_o  out  1  to CPU RDY; low stalls the CPU
- bus_grant_o  out  1  high means DMA owns the RAM port
- mem_addr_o  out  ADDR_W  RAM address (read and write)
- mem_wdata_o  out  8  RAM write data
- mem_rwn_o  out  1  RAM read/write-n
- mem_rdata_i  in  8  RAM read data
- done_o  out  1  level, high while STATUS.done is set

Behaviour:
- Registers:
  - 0/1 SRC_L/H, 2/3 DST_L/H, 4/5 LEN_L/H.
  - 6 CTRL: write bit0=start, bit1=fill (feature only); reads back bit1.
  - 7 STATUS: bit0 busy, bit1 done; any write to 7 clears done.
- Register write occurs when dma_cs & ~R_W_n, using reg_addr_i. data_o is combinational from reg_addr_r_i.
- Writes to regs 0-5 while busy are ignored. A start while busy is ignored.
- Reset values: all registers 0, cpu_rdy_o=1, bus_grant_o=0, mem_rwn_o=1, mem_addr_o=0, mem_wdata_o=0, done=0, state IDLE.
- FSM:
  - IDLE: on start with LEN≠0, latch working copies of SRC/DST/LEN, set busy, drop cpu_rdy_o next cycle, go to STALL. On start with LEN=0, set done the next cycle; no stall, no grant.
  - STALL: count GRACE_CYCLES, then assert bus_grant_o, go to READ.
  - READ: mem_addr_o=src, mem_rwn_o=1, go to RWAIT.
  - RWAIT: hold RAM_LAT cycles, capture mem_rdata_i, go to WRITE.
  - WRITE: mem_addr_o=dst, mem_wdata_o=byte, mem_rwn_o=0 for exactly one cycle; then src+1, dst+1, len-1. If len becomes 0 go to RELEASE, else go to READ.
  - RELEASE: mem_rwn_o=1, bus_grant_o=0; one cycle later cpu_rdy_o=1, busy=0, done=1; go to IDLE.
- Per-byte cost: 2+RAM_LAT cycles. Total stall: GRACE_CYCLES+LEN*(2+RAM_LAT)+2.
- Addresses wrap modulo 2^ADDR_W (0xFFFF+1→0x0000). LEN 0xFFFF is legal.
- Overlap: strict ascending byte order. With DST=SRC+1 the first byte is replicated; this is defined behaviour.
- Start and a STATUS write in the same cycle: the start is taken and done is cleared.
- Register reads during a transfer are impossible, because the CPU is stalled.
- Reset mid-transfer: immediate return to reset values. cpu_rdy_o=1 and bus_grant_o=0 asynchronously. The partial copy is not undone.

Optional Feature:
- DMA_FILL_EN defined:
  - CTRL.bit1 selects fill mode: SRC_L holds the fill byte; READ/RWAIT are skipped; 1 cycle per byte.
  - SRC registers are not incremented in fill mode.
- Undefined:
  - CTRL.bit1 is not stored and reads 0; copy mode only.

Decomposition:
- Shared package nano6502_pkg: IO bank constant DMA_BANK=8'h08, register offsets REG_SRC_L…REG_STATUS, CTRL/STATUS bit indices, FSM state enum dma_state_t.
- One sub-module, dma_stall_counter: the GRACE/RAM_LAT down-counter with load and zero flag, reused for both waits.

Test Plan:
- SRC=0x1000, DST=0x2000, LEN=4, RAM preloaded 11 22 33 44; start → cpu_rdy_o low for 2+4*3+2=16 cycles; 0x2000..3 = 11 22 33 44; STATUS=0x02.
- LEN=0, start → done=1 after 1 cycle; cpu_rdy_o never low; bus_grant_o never high.
- SRC=0xFFFE, DST=0x0100, LEN=3 → bytes read from 0xFFFE, 0xFFFF, 0x0000; written to 0x0100-0x0102.
- rst_n_i low during the 3rd WRITE → same cycle cpu_rdy_o=1, bus_grant_o=0; after release STATUS=0x00; only 2 bytes written.
- Start, then during the transfer a write SRC_L=0x55 plus a second start → ignored; the original copy completes unchanged; a write to STATUS clears done to 0x00.
- With DMA_FILL_EN: SRC_L=0xA5, DST=0x3000, LEN=5, CTRL=0x03 → 0x3000..4 = A5; stall = 2+5+2 cycles.
